idex_hazard_stage: RTL and testbench

IDEX_HAZARD_STAGE -- requirements
Module: idex_hazard_stage

---
 rtl/idex_hazard_stage_pkg.sv | 37 +++
 rtl/idex_hazard_stage_if.sv | 51 +++++
 rtl/idex_hazard_stage_dest_reg_sel.sv | 26 ++
 rtl/idex_hazard_stage.sv | 89 ++++++++
 tb/tb_idex_hazard_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/idex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its load-use hazard logic.
// Also used by the forwarding unit through dest_reg_sel.
package idex_hazard_stage_pkg;

    localparam int          DATA_W  = 16;
    localparam logic [15:0] NOP_ENC = 16'h0800;
    localparam logic [2:0]  RA_REG  = 3'h7;

    typedef enum logic [1:0] {
        WSEL_RS_RD_RT = 2'b00,
        WSEL_RD_R     = 2'b01,
        WSEL_RS       = 2'b10,
        WSEL_R7       = 2'b11
    } wsel_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc2;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic              rwe;
        logic [1:0]        wsel;
        logic              mem_rd;
        logic              mem_wr;
        logic              halt;
        logic              vld;
    } idex_t;

    function automatic idex_t bubble_entry(input logic [DATA_W-1:0] nop);
        idex_t e;
        e       = '0;
        e.instr = nop;
        return e;
    endfunction

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Signal bundle between the decode side (master) and the ID/EX stage (slave).
interface idex_hazard_stage_if;
    import idex_hazard_stage_pkg::*;

    logic [DATA_W-1:0] Instruction_IFID_out;
    logic [DATA_W-1:0] PC_plus2_IFID_out;
    logic [DATA_W-1:0] RegData1_ID;
    logic [DATA_W-1:0] RegData2_ID;
    logic [DATA_W-1:0] Imm_ID;
    logic              RegWriteEnable_ID;
    logic [1:0]        WriteRegSel_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic              Halt_ID;
    logic              UsesRs_ID;
    logic              UsesRt_ID;
    logic              Flush_EX;

    logic [DATA_W-1:0] Instruction_IDEX_out;
    logic [DATA_W-1:0] PC_plus2_IDEX_out;
    logic [DATA_W-1:0] RegData1_IDEX_out;
    logic [DATA_W-1:0] RegData2_IDEX_out;
    logic [DATA_W-1:0] Imm_IDEX_out;
    logic              RegWriteEnable_IDEX_out;
    logic [1:0]        WriteRegSel_IDEX_out;
    logic              MemRead_IDEX_out;
    logic              MemWrite_IDEX_out;
    logic              Halt_IDEX_out;
    logic              Valid_IDEX_out;
    logic [DATA_W-1:0] StallCount;
    logic              Stall_IFID;

    modport master (
        output Instruction_IFID_out, PC_plus2_IFID_out, RegData1_ID, RegData2_ID, Imm_ID,
               RegWriteEnable_ID, WriteRegSel_ID, MemRead_ID, MemWrite_ID, Halt_ID,
               UsesRs_ID, UsesRt_ID, Flush_EX,
        input  Instruction_IDEX_out, PC_plus2_IDEX_out, RegData1_IDEX_out, RegData2_IDEX_out,
               Imm_IDEX_out, RegWriteEnable_IDEX_out, WriteRegSel_IDEX_out, MemRead_IDEX_out,
               MemWrite_IDEX_out, Halt_IDEX_out, Valid_IDEX_out, StallCount, Stall_IFID
    );

    modport slave (
        input  Instruction_IFID_out, PC_plus2_IFID_out, RegData1_ID, RegData2_ID, Imm_ID,
               RegWriteEnable_ID, WriteRegSel_ID, MemRead_ID, MemWrite_ID, Halt_ID,
               UsesRs_ID, UsesRt_ID, Flush_EX,
        output Instruction_IDEX_out, PC_plus2_IDEX_out, RegData1_IDEX_out, RegData2_IDEX_out,
               Imm_IDEX_out, RegWriteEnable_IDEX_out, WriteRegSel_IDEX_out, MemRead_IDEX_out,
               MemWrite_IDEX_out, Halt_IDEX_out, Valid_IDEX_out, StallCount, Stall_IFID
    );

endinterface

// File: rtl/idex_hazard_stage_dest_reg_sel.sv
// Decodes which architectural register an instruction writes, from its WriteRegSel code.
// Shared with the forwarding unit so both agree on the destination.
module dest_reg_sel
    import idex_hazard_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_instr,
    input  logic [1:0]        i_wsel,
    output logic [2:0]        o_reg
);

    // Opcode and function bits never name a register.
    logic w_unused;
    assign w_unused = ^{i_instr[15:11], i_instr[1:0]};

    always_comb begin
        o_reg = i_instr[7:5];
        case (wsel_e'(i_wsel))
            WSEL_RS_RD_RT: o_reg = i_instr[7:5];
            WSEL_RD_R:     o_reg = i_instr[4:2];
            WSEL_RS:       o_reg = i_instr[10:8];
            WSEL_R7:       o_reg = RA_REG;
            default:       o_reg = i_instr[7:5];
        endcase
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or EX flush, and a saturating count of stall cycles.
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
    input  logic                clk,
    input  logic                rst,
    idex_hazard_stage_if.slave  bus
);

    idex_t             r_idex_p1;
    logic [DATA_W-1:0] r_stall_count;
    idex_t             w_next_p0;
    logic [2:0]        w_dest;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    dest_reg_sel u_dest_reg_sel (
        .i_instr (r_idex_p1.instr),
        .i_wsel  (r_idex_p1.wsel),
        .o_reg   (w_dest)
    );

    // Only a valid load that writes a register can starve the instruction behind it.
    assign w_rs_hit = bus.UsesRs_ID & (w_dest == bus.Instruction_IFID_out[10:8]);
    assign w_rt_hit = bus.UsesRt_ID & (w_dest == bus.Instruction_IFID_out[7:5]);
    assign w_hazard = r_idex_p1.vld & r_idex_p1.mem_rd & r_idex_p1.rwe & (w_rs_hit | w_rt_hit);
    assign w_stall  = w_hazard & ~bus.Flush_EX;
    assign w_bubble = w_hazard | bus.Flush_EX;

    // p0: select the word entering EX
    always_comb begin
        w_next_p0 = bubble_entry(NOP_INSTR);
        if (!w_bubble) begin
            w_next_p0.instr  = bus.Instruction_IFID_out;
            w_next_p0.pc2    = bus.PC_plus2_IFID_out;
            w_next_p0.data1  = bus.RegData1_ID;
            w_next_p0.data2  = bus.RegData2_ID;
            w_next_p0.imm    = bus.Imm_ID;
            w_next_p0.rwe    = bus.RegWriteEnable_ID;
            w_next_p0.wsel   = bus.WriteRegSel_ID;
            w_next_p0.mem_rd = bus.MemRead_ID;
            w_next_p0.mem_wr = bus.MemWrite_ID;
            w_next_p0.halt   = bus.Halt_ID;
            w_next_p0.vld    = 1'b1;
        end
    end

    // p1: ID/EX register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex_p1 <= bubble_entry(NOP_INSTR);
        end else begin
            r_idex_p1 <= w_next_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall) begin
            r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign bus.Instruction_IDEX_out    = r_idex_p1.instr;
    assign bus.PC_plus2_IDEX_out       = r_idex_p1.pc2;
    assign bus.RegData1_IDEX_out       = r_idex_p1.data1;
    assign bus.RegData2_IDEX_out       = r_idex_p1.data2;
    assign bus.Imm_IDEX_out            = r_idex_p1.imm;
    assign bus.RegWriteEnable_IDEX_out = r_idex_p1.rwe;
    assign bus.WriteRegSel_IDEX_out    = r_idex_p1.wsel;
    assign bus.MemRead_IDEX_out        = r_idex_p1.mem_rd;
    assign bus.MemWrite_IDEX_out       = r_idex_p1.mem_wr;
    assign bus.Halt_IDEX_out           = r_idex_p1.halt;
    assign bus.Valid_IDEX_out          = r_idex_p1.vld;
    assign bus.StallCount              = r_stall_count;
    assign bus.Stall_IFID              = w_stall;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed bench for idex_hazard_stage: a behavioural model checked every negedge,
// plus literal expectations for the load-use, flush, reset and saturation cases.
module tb_idex_hazard_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    idex_hazard_stage_if bus_if ();

    idex_hazard_stage #(.NOP_INSTR(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] imm;
        logic        rwe;
        logic [1:0]  wsel;
        logic        mr;
        logic        mw;
        logic        halt;
        logic        vld;
    } ent_t;

    ent_t m;
    int   m_nstall = 0;
    int   cnt_base = 0;
    int   preset_mark = 0;

    function automatic ent_t bubble();
        ent_t e;
        e = '0;
        e.instr = 16'h0800;
        return e;
    endfunction

    function automatic logic [2:0] model_dest(input logic [15:0] i, input logic [1:0] w);
        case (w)
            2'b00:   return i[7:5];
            2'b01:   return i[4:2];
            2'b10:   return i[10:8];
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic m_hazard();
        logic [2:0] d;
        d = model_dest(m.instr, m.wsel);
        return m.vld && m.mr && m.rwe &&
               ((bus_if.UsesRs_ID && d == bus_if.Instruction_IFID_out[10:8]) ||
                (bus_if.UsesRt_ID && d == bus_if.Instruction_IFID_out[7:5]));
    endfunction

    function automatic logic [15:0] exp_count();
        int v;
        v = cnt_base + m_nstall - preset_mark;
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m        <= bubble();
            m_nstall <= 0;
        end else begin
            if (m_hazard() && !bus_if.Flush_EX) m_nstall <= m_nstall + 1;
            if (m_hazard() || bus_if.Flush_EX) begin
                m <= bubble();
            end else begin
                m <= '{instr: bus_if.Instruction_IFID_out, pc: bus_if.PC_plus2_IFID_out,
                       d1: bus_if.RegData1_ID, d2: bus_if.RegData2_ID, imm: bus_if.Imm_ID,
                       rwe: bus_if.RegWriteEnable_ID, wsel: bus_if.WriteRegSel_ID,
                       mr: bus_if.MemRead_ID, mw: bus_if.MemWrite_ID, halt: bus_if.Halt_ID,
                       vld: 1'b1};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        chk("instr", bus_if.Instruction_IDEX_out, m.instr);
        chk("pc2",   bus_if.PC_plus2_IDEX_out, m.pc);
        chk("data1", bus_if.RegData1_IDEX_out, m.d1);
        chk("data2", bus_if.RegData2_IDEX_out, m.d2);
        chk("imm",   bus_if.Imm_IDEX_out, m.imm);
        chk("ctrl",  {bus_if.RegWriteEnable_IDEX_out, bus_if.WriteRegSel_IDEX_out,
                      bus_if.MemRead_IDEX_out, bus_if.MemWrite_IDEX_out,
                      bus_if.Halt_IDEX_out, bus_if.Valid_IDEX_out},
                     {m.rwe, m.wsel, m.mr, m.mw, m.halt, m.vld});
        chk("count", bus_if.StallCount, exp_count());
        chk("stall", bus_if.Stall_IFID, rst ? 1'b0 : (m_hazard() && !bus_if.Flush_EX));
    end

    task automatic set_id(input logic [15:0] instr, input logic [15:0] pc, input logic rwe,
                          input logic [1:0] wsel, input logic mr, input logic mw,
                          input logic halt, input logic urs, input logic urt, input logic flush);
        bus_if.Instruction_IFID_out = instr;
        bus_if.PC_plus2_IFID_out    = pc;
        bus_if.RegData1_ID          = pc + 16'h0100;
        bus_if.RegData2_ID          = pc ^ 16'h5A5A;
        bus_if.Imm_ID               = {8'h00, instr[7:0]};
        bus_if.RegWriteEnable_ID    = rwe;
        bus_if.WriteRegSel_ID       = wsel;
        bus_if.MemRead_ID           = mr;
        bus_if.MemWrite_ID          = mw;
        bus_if.Halt_ID              = halt;
        bus_if.UsesRs_ID            = urs;
        bus_if.UsesRt_ID            = urt;
        bus_if.Flush_EX             = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [15:0] instr, input logic [1:0] wsel);
        set_id(instr, 16'h0010, 1'b1, wsel, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_add(input logic flush);
        set_id(16'hDA8C, 16'h0012, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, flush);
    endtask

    // Load in IDEX with the given destination, then a reader in ID; stall predicted by hand.
    task automatic scen(input string name, input logic [15:0] ld_i, input logic [1:0] ld_w,
                        input logic [15:0] id_i, input logic urs, input logic urt,
                        input logic halt, input logic exp_stall);
        set_ld(ld_i, ld_w);
        tick();
        set_id(id_i, 16'h0020, 1'b1, 2'b00, 1'b0, 1'b0, halt, urs, urt, 1'b0);
        #1 chk(name, bus_if.Stall_IFID, exp_stall);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_id(16'h0000, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        #1;
        chk("rst_instr", bus_if.Instruction_IDEX_out, 16'h0800);
        chk("rst_valid", bus_if.Valid_IDEX_out, 1'b0);
        chk("rst_count", bus_if.StallCount, 16'h0000);
        chk("rst_stall", bus_if.Stall_IFID, 1'b0);
        rst = 1'b0;
        tick();

        // LD r2,r1,0 followed by ADD r3,r2,r4
        set_ld(16'h8940, 2'b00);
        tick();
        set_add(1'b0);
        #1 chk("lu_stall", bus_if.Stall_IFID, 1'b1);
        tick();
        chk("lu_bub_instr", bus_if.Instruction_IDEX_out, 16'h0800);
        chk("lu_bub_valid", bus_if.Valid_IDEX_out, 1'b0);
        chk("lu_count", bus_if.StallCount, 16'h0001);
        chk("lu_unstall", bus_if.Stall_IFID, 1'b0);
        tick();
        chk("lu_adv_instr", bus_if.Instruction_IDEX_out, 16'hDA8C);
        chk("lu_adv_valid", bus_if.Valid_IDEX_out, 1'b1);

        // Reader of r5,r6 only
        set_ld(16'h8940, 2'b00);
        tick();
        set_id(16'hD5C0, 16'h0014, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("nohz_stall", bus_if.Stall_IFID, 1'b0);
        tick();
        chk("nohz_instr", bus_if.Instruction_IDEX_out, 16'hD5C0);
        chk("nohz_count", bus_if.StallCount, 16'h0001);

        // Flush overrides hazard
        set_ld(16'h8940, 2'b00);
        tick();
        set_add(1'b1);
        #1 chk("fl_stall", bus_if.Stall_IFID, 1'b0);
        tick();
        chk("fl_instr", bus_if.Instruction_IDEX_out, 16'h0800);
        chk("fl_valid", bus_if.Valid_IDEX_out, 1'b0);
        chk("fl_count", bus_if.StallCount, 16'h0001);

        // Store writing a matching register never stalls
        set_id(16'h8940, 16'h0016, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_add(1'b0);
        #1 chk("st_stall", bus_if.Stall_IFID, 1'b0);
        tick();
        chk("st_instr", bus_if.Instruction_IDEX_out, 16'hDA8C);

        // Destination selection and operand fields
        scen("ws01_rs", 16'h8914, 2'b01, 16'hC500, 1'b1, 1'b0, 1'b0, 1'b1);
        scen("ws10_rt", 16'h8B40, 2'b10, 16'hC060, 1'b0, 1'b1, 1'b0, 1'b1);
        scen("ws11_rt", 16'h8900, 2'b11, 16'hC0E0, 1'b0, 1'b1, 1'b0, 1'b1);
        scen("ws11_miss", 16'h8900, 2'b11, 16'hC0C0, 1'b0, 1'b1, 1'b0, 1'b0);
        scen("rs_unused", 16'h8940, 2'b00, 16'hC200, 1'b0, 1'b0, 1'b0, 1'b0);
        scen("r0_dest", 16'h8900, 2'b00, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Halt is squashed in a bubble but propagates when valid
        set_ld(16'h8940, 2'b00);
        tick();
        set_id(16'h0200, 16'h0030, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("halt_bub", bus_if.Halt_IDEX_out, 1'b0);
        tick();
        chk("halt_vld", bus_if.Halt_IDEX_out, 1'b1);

        // Back-to-back loads: LD r3,r2 after LD r2, then a reader of r3
        set_ld(16'h8940, 2'b00);
        tick();
        set_id(16'h8A60, 16'h0040, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("b2b_stall1", bus_if.Stall_IFID, 1'b1);
        tick();
        tick();
        chk("b2b_ld2", bus_if.Instruction_IDEX_out, 16'h8A60);
        set_id(16'hDB00, 16'h0042, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("b2b_stall2", bus_if.Stall_IFID, 1'b1);
        tick();
        tick();
        chk("b2b_adv", bus_if.Instruction_IDEX_out, 16'hDB00);

        // Asynchronous reset in the middle of a stall
        set_ld(16'h8940, 2'b00);
        tick();
        set_add(1'b0);
        #1 chk("ars_pre", bus_if.Stall_IFID, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("ars_instr", bus_if.Instruction_IDEX_out, 16'h0800);
        chk("ars_valid", bus_if.Valid_IDEX_out, 1'b0);
        chk("ars_count", bus_if.StallCount, 16'h0000);
        chk("ars_stall", bus_if.Stall_IFID, 1'b0);
        #1 rst = 1'b0;
        tick();
        chk("ars_load", bus_if.Instruction_IDEX_out, 16'hDA8C);
        chk("ars_lvld", bus_if.Valid_IDEX_out, 1'b1);

        // Saturation from a preset of FFFE
        force dut.r_stall_count = 16'hFFFE;
        preset_mark = m_nstall;
        cnt_base    = 16'hFFFE;
        #1 release dut.r_stall_count;
        tick();
        for (int k = 0; k < 3; k++) begin
            set_ld(16'h8940, 2'b00);
            tick();
            set_add(1'b0);
            tick();
            chk($sformatf("sat%0d", k), bus_if.StallCount, 16'hFFFF);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
